// File: rtl/branch_predictor_bht_pkg.sv
// Shared constants for the bimodal branch history table.
// Counter encoding: SNT=00, WNT=01, WT=10, ST=11; the MSB is the prediction.
package branch_predictor_bht_pkg;

  localparam logic [1:0] BP_SNT      = 2'b00;
  localparam logic [1:0] BP_WNT      = 2'b01;
  localparam logic [1:0] BP_WT       = 2'b10;
  localparam logic [1:0] BP_ST       = 2'b11;
  localparam logic [1:0] BP_CTR_INIT = BP_WNT;

endpackage : branch_predictor_bht_pkg

// File: rtl/branch_predictor_bht_sat_ctr2.sv
// bp_sat_ctr2: combinational next-state for one 2-bit saturating counter.
// A taken outcome moves the counter towards ST and a not-taken outcome moves it
// towards SNT. The counter saturates at both ends and never wraps.
module bp_sat_ctr2
  import branch_predictor_bht_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  // Step the counter one state towards the observed outcome, holding at the ends.
  always_comb begin
    ctr_next = BP_CTR_INIT;
    case (ctr)
      BP_SNT: begin
        if (taken) ctr_next = BP_WNT;
        else       ctr_next = BP_SNT;
      end
      BP_WNT: begin
        if (taken) ctr_next = BP_WT;
        else       ctr_next = BP_SNT;
      end
      BP_WT: begin
        if (taken) ctr_next = BP_ST;
        else       ctr_next = BP_WNT;
      end
      BP_ST: begin
        if (taken) ctr_next = BP_ST;
        else       ctr_next = BP_WT;
      end
      default: ctr_next = BP_CTR_INIT;
    endcase
  end

endmodule : bp_sat_ctr2

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: bimodal branch history table of 2-bit saturating counters.
// ID looks the table up combinationally. EX/M writes the resolved outcome back and
// receives a mispredict flag. The table has no tags, so PCs that share index bits
// share a counter. A lookup and an update to the same entry in the same cycle
// return the old value, because there is no bypass path.
// Optional feature: define BP_STATS_EN to build the saturating resolved-branch
// counter and mispredict counter. Without it, stat_* are tied to zero.
module branch_predictor_bht
  import branch_predictor_bht_pkg::*;
#(
  parameter int IDX_W   = 6,
  parameter int STATS_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        id_pc,
  input  logic               id_is_branch,
  output logic               br_pred_taken,
  input  logic               ex_br_valid,
  input  logic [31:0]        ex_pc,
  input  logic               ex_br_taken,
  input  logic               ex_pred_taken,
  output logic               mispredict,
  output logic [STATS_W-1:0] stat_branches,
  output logic [STATS_W-1:0] stat_mispred
);

  localparam int TBL_N = 1 << IDX_W;

  logic [1:0]       ctr_r [0:TBL_N-1];
  logic [IDX_W-1:0] id_idx_s;
  logic [IDX_W-1:0] ex_idx_s;
  logic [1:0]       ctr_next_s;
  logic             mispredict_raw_s;
  logic             unused_pc_bits_s;

  // The index is the word address of the PC. Byte-offset bits and upper bits are not used.
  assign id_idx_s         = id_pc[IDX_W+1:2];
  assign ex_idx_s         = ex_pc[IDX_W+1:2];
  assign unused_pc_bits_s = ^{id_pc[31:IDX_W+2], id_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0]};
  assign mispredict_raw_s = ex_br_valid & (ex_br_taken != ex_pred_taken);

  bp_sat_ctr2 u_sat_ctr2 (
    .ctr      (ctr_r[ex_idx_s]),
    .taken    (ex_br_taken),
    .ctr_next (ctr_next_s)
  );

  // Table storage: reset every entry to WNT (reset wins over a concurrent update),
  // otherwise write back the stepped counter for a resolved branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TBL_N; i++) begin
        ctr_r[i] <= BP_CTR_INIT;
      end
    end else if (ex_br_valid) begin
      ctr_r[ex_idx_s] <= ctr_next_s;
    end
  end

  // Prediction and mispredict flag, both held low while reset is asserted.
  always_comb begin
    br_pred_taken = 1'b0;
    mispredict    = 1'b0;
    if (rst) begin
      br_pred_taken = 1'b0;
      mispredict    = 1'b0;
    end else begin
      if (id_is_branch) br_pred_taken = ctr_r[id_idx_s][1];
      else              br_pred_taken = 1'b0;
      mispredict = mispredict_raw_s;
    end
  end

`ifdef BP_STATS_EN
  logic [STATS_W-1:0] stat_branches_r;
  logic [STATS_W-1:0] stat_mispred_r;

  // Statistics: count resolved branches and mispredicts, holding at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_r <= {STATS_W{1'b0}};
      stat_mispred_r  <= {STATS_W{1'b0}};
    end else begin
      if (ex_br_valid && (stat_branches_r != {STATS_W{1'b1}})) begin
        stat_branches_r <= stat_branches_r + {{(STATS_W-1){1'b0}}, 1'b1};
      end
      if (mispredict_raw_s && (stat_mispred_r != {STATS_W{1'b1}})) begin
        stat_mispred_r <= stat_mispred_r + {{(STATS_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stat_branches = stat_branches_r;
  assign stat_mispred  = stat_mispred_r;
`else
  assign stat_branches = {STATS_W{1'b0}};
  assign stat_mispred  = {STATS_W{1'b0}};
`endif

endmodule : branch_predictor_bht

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht. A table of one-cycle vectors holds
// hand-computed expected outputs. Hand-written sequences cover reset during an
// update and the statistics counters.
module tb_branch_predictor_bht;

  logic        clk;
  logic        rst;
  logic [31:0] id_pc;
  logic        id_is_branch;
  logic        br_pred_taken;
  logic        ex_br_valid;
  logic [31:0] ex_pc;
  logic        ex_br_taken;
  logic        ex_pred_taken;
  logic        mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int checks = 0;
  int errors = 0;

  branch_predictor_bht #(.IDX_W(6), .STATS_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_pc         (id_pc),
    .id_is_branch  (id_is_branch),
    .br_pred_taken (br_pred_taken),
    .ex_br_valid   (ex_br_valid),
    .ex_pc         (ex_pc),
    .ex_br_taken   (ex_br_taken),
    .ex_pred_taken (ex_pred_taken),
    .mispredict    (mispredict),
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] id_pc;
    logic        id_br;
    logic        ex_v;
    logic [31:0] ex_pc;
    logic        ex_t;
    logic        ex_p;
    logic        exp_pred;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic r, input logic [31:0] ipc, input logic ib,
                      input logic ev, input logic [31:0] epc, input logic et,
                      input logic ep, input logic xp, input logic xm);
    vec_t v;
    v.rst = r; v.id_pc = ipc; v.id_br = ib; v.ex_v = ev; v.ex_pc = epc;
    v.ex_t = et; v.ex_p = ep; v.exp_pred = xp; v.exp_mis = xm;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive the inputs at the falling edge and let them settle for 1 time unit.
  task automatic drive(input logic r, input logic [31:0] ipc, input logic ib,
                       input logic ev, input logic [31:0] epc, input logic et, input logic ep);
    @(negedge clk);
    rst = r; id_pc = ipc; id_is_branch = ib; ex_br_valid = ev;
    ex_pc = epc; ex_br_taken = et; ex_pred_taken = ep;
    #1;
  endtask

  task automatic idle_lookup(input logic [31:0] ipc);
    drive(1'b0, ipc, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; id_pc = 32'h0; id_is_branch = 1'b0; ex_br_valid = 1'b0;
    ex_pc = 32'h0; ex_br_taken = 1'b0; ex_pred_taken = 1'b0;

    //   rst   id_pc         br    ev    ex_pc         t     p     pred  mis
    // Reset with an update pending. Reset wins and the outputs are forced low.
    addv(1'b1, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 32'h0000_0040, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0);
    // Training at 0x40: one taken update, then predict taken; 0x44 is unaffected.
    addv(1'b0, 32'h0000_0044, 1'b1, 1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b1);
    addv(1'b0, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0040, 1'b1, 1'b0, 1'b1, 1'b0);
    addv(1'b0, 32'h0000_0044, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0);
    // Saturation at 0x80: five taken updates.
    addv(1'b0, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b0, 1'b0);
    addv(1'b0, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b1, 1'b0);
    addv(1'b0, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b1, 1'b0);
    addv(1'b0, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b1, 1'b0);
    addv(1'b0, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b1, 1'b0);
    // First not-taken: ST -> WT, still predicts 1. Second: WT -> WNT, predicts 0.
    addv(1'b0, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b1, 1'b1, 1'b1);
    addv(1'b0, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b1, 1'b1, 1'b1);
    addv(1'b0, 32'h0000_0080, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0);
    // Five not-taken updates saturate at SNT.
    addv(1'b0, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b0);
    addv(1'b0, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b0);
    // One taken update after saturation: SNT -> WNT, still predicts 0.
    addv(1'b0, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 1'b1);
    addv(1'b0, 32'h0000_0080, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0);
    // Alias: 0x10 and 0x110 share index 4.
    addv(1'b0, 32'h0000_0110, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b1);
    addv(1'b0, 32'h0000_0110, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0);
    // ex_pc[1:0] and id_pc[1:0] are ignored: 0x113 and 0x12 also map to index 4.
    addv(1'b0, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_0113, 1'b0, 1'b1, 1'b1, 1'b1);
    addv(1'b0, 32'h0000_0012, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0);
    // Same-cycle collision at 0xC0: the lookup sees the old WNT, then WT next cycle.
    addv(1'b0, 32'h0000_00C0, 1'b1, 1'b1, 32'h0000_00C0, 1'b1, 1'b0, 1'b0, 1'b1);
    addv(1'b0, 32'h0000_00C0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0);
    // The upper PC bits are ignored.
    addv(1'b0, 32'hFFFF_FFC0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].id_pc, vecs[i].id_br, vecs[i].ex_v,
            vecs[i].ex_pc, vecs[i].ex_t, vecs[i].ex_p);
      check($sformatf("vec%0d_pred", i), {31'h0, br_pred_taken}, {31'h0, vecs[i].exp_pred});
      check($sformatf("vec%0d_mis", i), {31'h0, mispredict}, {31'h0, vecs[i].exp_mis});
    end

    // Reset during an update: train 0x200 to ST, then assert rst with a taken update.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
    idle_lookup(32'h0000_0200);
    check("trained_0x200", {31'h0, br_pred_taken}, 32'h1);
    drive(1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
    check("rst_forces_pred", {31'h0, br_pred_taken}, 32'h0);
    check("rst_forces_mis", {31'h0, mispredict}, 32'h0);
    idle_lookup(32'h0000_0200);
    check("rst_wins_0x200", {31'h0, br_pred_taken}, 32'h0);
    idle_lookup(32'h0000_00C0);
    check("rst_clears_0xC0", {31'h0, br_pred_taken}, 32'h0);

    // Statistics: 3 branches with 1 mispredict. A cycle with ex_br_valid=0 must not count.
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0300, 1'b1, 1'b0);
    check("invalid_no_mis", {31'h0, mispredict}, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b0);
    check("mis_taken_pred0", {31'h0, mispredict}, 32'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0304, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef BP_STATS_EN
    check("stat_branches", stat_branches, 32'd3);
    check("stat_mispred", stat_mispred, 32'd1);
`else
    check("stat_branches_off", stat_branches, 32'd0);
    check("stat_mispred_off", stat_mispred, 32'd0);
`endif
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("stat_branches_rst", stat_branches, 32'd0);
    check("stat_mispred_rst", stat_mispred, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_branch_predictor_bht
